// File: rtl/miner_job_ctrl.sv
// Mining job sequencer: gathers a block header from UART bytes, runs one hasher job,
// and frames the result (A5 + nonce, or 5A when exhausted) back out to the UART.
module miner_job_ctrl #(
   parameter int unsigned HEADER_BYTES = 80,
   parameter int unsigned BYTE_TIMEOUT = 50000,
   parameter int unsigned TMO_W        = 16
) (
   input  logic                      clock,
   input  logic                      reset,
   input  logic                      rx_valid,
   input  logic [7:0]                rx_byte,
   output logic [HEADER_BYTES*8-1:0] hdr_data,
   output logic                      job_start,
   output logic                      job_abort,
   input  logic                      found,
   input  logic [31:0]               found_nonce,
   input  logic                      exhausted,
   output logic [7:0]                tx_byte,
   output logic                      tx_wr,
   input  logic                      tx_busy,
   output logic                      job_active,
   output logic [6:0]                hdr_count
);

   localparam int unsigned HW = HEADER_BYTES * 8;

   typedef enum logic [2:0] {StIdle, StStart, StMine, StSend, StWaitTx} state_e;

   state_e            state_q, state_d;
   logic [HW-1:0]     shadow;
   logic              copy_pend;
   logic              hdr_ready;
   logic [TMO_W-1:0]  tmo_cnt;
   logic              partial;
   logic              tmo_hit;
   logic [39:0]       frame_q;
   logic [2:0]        left_q;
   logic              guard_q;

   assign partial = (hdr_count != 7'd0) && (hdr_count < 7'(HEADER_BYTES));
   // A byte arriving on the timeout cycle takes priority and restarts the count.
   assign tmo_hit = partial && !rx_valid && (tmo_cnt == TMO_W'(BYTE_TIMEOUT - 1));

   // Receive path: independent of the job FSM.
   always_ff @(posedge clock) begin
      if (reset) begin
         shadow    <= '0;
         hdr_data  <= '0;
         hdr_count <= 7'd0;
         copy_pend <= 1'b0;
         hdr_ready <= 1'b0;
         tmo_cnt   <= '0;
      end else begin
         copy_pend <= 1'b0;
         if (rx_valid) shadow <= {shadow[HW-9:0], rx_byte};

         if (copy_pend) begin
            hdr_data  <= shadow;
            hdr_count <= rx_valid ? 7'd1 : 7'd0;
         end else if (rx_valid) begin
            hdr_count <= hdr_count + 7'd1;
            copy_pend <= (hdr_count == 7'(HEADER_BYTES - 1));
         end else if (tmo_hit) begin
            hdr_count <= 7'd0;
         end

         if (rx_valid || !partial || tmo_hit) tmo_cnt <= '0;
         else                                 tmo_cnt <= tmo_cnt + TMO_W'(1);

         if (copy_pend)               hdr_ready <= 1'b1;
         else if (state_q == StIdle)  hdr_ready <= 1'b0;
      end
   end

   always_comb begin
      state_d   = state_q;
      job_start = 1'b0;
      job_abort = 1'b0;
      tx_wr     = 1'b0;
      unique case (state_q)
         StIdle:  if (hdr_ready) state_d = StStart;
         StStart: begin
            job_start = 1'b1;
            state_d   = StMine;
         end
         StMine: begin
            if (rx_valid) begin
               job_abort = 1'b1;
               state_d   = StIdle;
            end else if (found || exhausted) begin
               state_d = StSend;
            end
         end
         StSend: begin
            if (!tx_busy) begin
               tx_wr   = 1'b1;
               state_d = StWaitTx;
            end
         end
         StWaitTx: begin
            if (!guard_q && !tx_busy) state_d = (left_q == 3'd0) ? StIdle : StSend;
         end
         default: state_d = StIdle;
      endcase
   end

   assign job_active = (state_q == StStart) || (state_q == StMine);
   assign tx_byte    = frame_q[39:32];

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= StIdle;
         frame_q <= '0;
         left_q  <= 3'd0;
         guard_q <= 1'b0;
      end else begin
         state_q <= state_d;
         // Hold off one cycle after each write so a late tx_busy rise is not missed.
         guard_q <= tx_wr;
         if (state_q == StMine && !rx_valid) begin
            if (found) begin
               frame_q <= {8'hA5, found_nonce};
               left_q  <= 3'd5;
            end else if (exhausted) begin
               frame_q <= {8'h5A, 32'h0};
               left_q  <= 3'd1;
            end
         end
         if (tx_wr) begin
            frame_q <= {frame_q[31:0], 8'h00};
            left_q  <= left_q - 3'd1;
         end
      end
   end

endmodule

// File: tb/tb_miner_job_ctrl.sv
// Scoreboard bench for miner_job_ctrl: expected tx bytes are queued when the hasher
// result is driven and popped as the DUT writes them.
module tb_miner_job_ctrl;

   localparam int unsigned TMO = 1000;

   logic         clock = 1'b0;
   logic         reset;
   logic         rx_valid;
   logic [7:0]   rx_byte;
   logic [639:0] hdr_data;
   logic         job_start;
   logic         job_abort;
   logic         found;
   logic [31:0]  found_nonce;
   logic         exhausted;
   logic [7:0]   tx_byte;
   logic         tx_wr;
   logic         tx_busy;
   logic         job_active;
   logic [6:0]   hdr_count;

   int n_checks = 0;
   int n_errors = 0;
   int cyc = 0;
   int n_start = 0;
   int n_abort = 0;
   int n_txwr = 0;
   int start_cyc = 0;
   int last_cyc = 0;

   logic [7:0]   sb[$];
   logic [8:0]   sb_exp;
   logic [639:0] exp_hdr = '0;
   logic [639:0] hdr_prev;
   bit           busy_en = 1'b0;
   bit           busy_pend = 1'b0;
   int           busy_cnt = 0;

   miner_job_ctrl #(
      .HEADER_BYTES (80),
      .BYTE_TIMEOUT (TMO),
      .TMO_W        (16)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .rx_valid    (rx_valid),
      .rx_byte     (rx_byte),
      .hdr_data    (hdr_data),
      .job_start   (job_start),
      .job_abort   (job_abort),
      .found       (found),
      .found_nonce (found_nonce),
      .exhausted   (exhausted),
      .tx_byte     (tx_byte),
      .tx_wr       (tx_wr),
      .tx_busy     (tx_busy),
      .job_active  (job_active),
      .hdr_count   (hdr_count)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc++;

   task automatic check(input string tag, input logic [639:0] got, input logic [639:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Monitor + UART busy model (busy rises one cycle after tx_wr, lasts 10 cycles).
   always @(negedge clock) begin
      if (tx_wr) begin
         n_txwr++;
         check("tx_busy_at_wr", 640'(tx_busy), 640'(0));
         sb_exp = (sb.size() > 0) ? {1'b0, sb.pop_front()} : 9'h100;
         check("tx_byte", 640'({1'b0, tx_byte}), 640'(sb_exp));
      end
      if (job_start) begin
         n_start++;
         start_cyc = cyc;
      end
      if (job_abort) n_abort++;
      if (busy_pend) begin
         tx_busy   = 1'b1;
         busy_cnt  = 10;
         busy_pend = 1'b0;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) tx_busy = 1'b0;
      end
      if (tx_wr && busy_en) busy_pend = 1'b1;
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge clock);
      rx_valid = 1'b1;
      rx_byte  = b;
      @(negedge clock);
      rx_valid = 1'b0;
   endtask

   task automatic send_header(input logic [7:0] base, input int n);
      int s0 = n_start;
      for (int i = 0; i < n; i++) begin
         send_byte(base + 8'(i));
         exp_hdr = {exp_hdr[631:0], base + 8'(i)};
      end
      last_cyc = cyc;
      repeat (4) @(negedge clock);
      #1;
      check("job_start_cnt", 640'(n_start - s0), 640'(1));
      check("start_latency", 640'(start_cyc - last_cyc), 640'(2));
      check("hdr_data", hdr_data, exp_hdr);
      check("hdr_count_clr", 640'(hdr_count), 640'(0));
      check("job_active", 640'(job_active), 640'(1));
   endtask

   task automatic hasher(input logic f, input logic e, input logic [31:0] n);
      @(negedge clock);
      found       = f;
      exhausted   = e;
      found_nonce = n;
      @(negedge clock);
      found     = 1'b0;
      exhausted = 1'b0;
   endtask

   task automatic drain(input int base, input int n_exp);
      repeat (200) @(negedge clock);
      #1;
      check("sb_drained", 640'(sb.size()), 640'(0));
      check("tx_wr_count", 640'(n_txwr - base), 640'(n_exp));
      check("idle_after_frame", 640'(job_active), 640'(0));
   endtask

   initial begin
      int b;
      int w;
      reset = 1'b1; rx_valid = 1'b0; rx_byte = 8'h00; found = 1'b0;
      found_nonce = 32'h0; exhausted = 1'b0; tx_busy = 1'b0;
      repeat (3) @(negedge clock);
      check("rst_hdr_data", hdr_data, 640'(0));
      check("rst_hdr_count", 640'(hdr_count), 640'(0));
      check("rst_outs", 640'({job_start, job_abort, tx_wr, job_active, tx_byte}), 640'(0));
      reset = 1'b0;

      // Header 00..4F then exhausted -> single 5A.
      send_header(8'h00, 80);
      check("hdr_first_byte", 640'(hdr_data[639:632]), 640'(8'h00));
      check("hdr_last_byte", 640'(hdr_data[7:0]), 640'(8'h4F));
      b = n_txwr;
      sb.push_back(8'h5A);
      hasher(1'b0, 1'b1, 32'h0);
      check("exh_to_wr", 640'(tx_wr), 640'(1));
      drain(b, 1);

      // Found DEADBEEF with a slow transmitter.
      busy_en = 1'b1;
      send_header(8'h10, 80);
      b = n_txwr;
      sb.push_back(8'hA5); sb.push_back(8'hDE); sb.push_back(8'hAD);
      sb.push_back(8'hBE); sb.push_back(8'hEF);
      hasher(1'b1, 1'b0, 32'hDEADBEEF);
      check("found_to_wr", 640'(tx_wr), 640'(1));
      drain(b, 5);
      busy_en = 1'b0;

      // Partial header times out; fresh header replaces only after completion.
      hdr_prev = hdr_data;
      b = n_start;
      for (int i = 0; i < 40; i++) send_byte(8'hF0);
      repeat (TMO - 10) @(negedge clock);
      check("pre_timeout_count", 640'(hdr_count), 640'(40));
      repeat (20) @(negedge clock);
      check("post_timeout_count", 640'(hdr_count), 640'(0));
      check("timeout_keeps_hdr", hdr_data, hdr_prev);
      check("timeout_no_start", 640'(n_start - b), 640'(0));
      send_header(8'h80, 80);

      // Abort: rx_valid and found in the same MINE cycle.
      b = n_txwr;
      w = n_abort;
      @(negedge clock);
      rx_valid = 1'b1; rx_byte = 8'hC0; found = 1'b1; found_nonce = 32'h11111111;
      @(negedge clock);
      rx_valid = 1'b0; found = 1'b0;
      exp_hdr = {exp_hdr[631:0], 8'hC0};
      repeat (20) @(negedge clock);
      #1;
      check("abort_pulse", 640'(n_abort - w), 640'(1));
      check("abort_no_tx", 640'(n_txwr - b), 640'(0));
      check("abort_hdr_count", 640'(hdr_count), 640'(1));
      check("abort_idle", 640'(job_active), 640'(0));

      // Found and exhausted together: found wins.
      send_header(8'hC1, 79);
      b = n_txwr;
      sb.push_back(8'hA5); sb.push_back(8'h12); sb.push_back(8'h34);
      sb.push_back(8'h56); sb.push_back(8'h78);
      hasher(1'b1, 1'b1, 32'h12345678);
      drain(b, 5);

      // Hasher strobes outside MINE are ignored.
      b = n_txwr;
      hasher(1'b1, 1'b1, 32'h55555555);
      repeat (20) @(negedge clock);
      #1;
      check("ignored_outside_mine", 640'(n_txwr - b), 640'(0));

      // Reset after the second byte of a found frame.
      busy_en = 1'b1;
      send_header(8'h33, 80);
      b = n_txwr;
      sb.push_back(8'hA5); sb.push_back(8'hCA); sb.push_back(8'hFE);
      sb.push_back(8'hF0); sb.push_back(8'h0D);
      hasher(1'b1, 1'b0, 32'hCAFEF00D);
      w = 0;
      while (n_txwr < b + 2 && w < 100) begin
         @(negedge clock);
         #1;
         w++;
      end
      check("second_wr_seen", 640'(n_txwr - b), 640'(2));
      reset = 1'b1;
      @(negedge clock);
      #1;
      check("rst_mid_outs", 640'({job_start, job_abort, tx_wr, job_active, tx_byte}), 640'(0));
      check("rst_mid_count", 640'(hdr_count), 640'(0));
      check("rst_mid_hdr", hdr_data, 640'(0));
      reset = 1'b0;
      busy_en = 1'b0;
      check("rst_mid_sb_left", 640'(sb.size()), 640'(3));
      sb.delete();
      repeat (100) @(negedge clock);
      #1;
      check("rst_mid_no_more_wr", 640'(n_txwr - b), 640'(2));
      check("rst_mid_idle", 640'(job_active), 640'(0));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
